// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
// Turns debounced button levels into Bomberman player tile moves and bomb
// requests. A move attempt reads the target tile through a map read port with
// one cycle of latency. The player moves only if that tile is empty. Every
// attempt is followed by a fixed cooldown, so a held button repeats at a
// steady rate.
//
// Ports
//   CLK, RESET        system clock, asynchronous active-high reset
//   up/down/left/right_dpb, mid_dpb
//                     debounced button levels (mid = bomb)
//   alive             1 = player may act
//   respawn           one-cycle pulse, reloads the start state
//   bomb_busy         1 = a bomb is already active, refuse new requests
//   map_rd_en/x/y     registered map read request
//   map_tile          tile code, valid the cycle after map_rd_en
//                     (0 empty, 1 hard wall, 2 soft block, 3 bomb)
//   player_x/y        current tile position
//   facing            00 up, 01 down, 10 left, 11 right
//   moved             one-cycle pulse on the first cycle of a new position
//   bomb_req, bomb_x/y one-cycle bomb placement pulse and its tile
// -----------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int GRID_W     = 15,
    parameter int GRID_H     = 13,
    parameter int START_X    = 1,
    parameter int START_Y    = 1,
    parameter int MOVE_TICKS = 25_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       up_dpb,
    input  logic       down_dpb,
    input  logic       left_dpb,
    input  logic       right_dpb,
    input  logic       mid_dpb,
    input  logic       alive,
    input  logic       respawn,
    input  logic       bomb_busy,
    output logic       map_rd_en,
    output logic [3:0] map_x,
    output logic [3:0] map_y,
    input  logic [1:0] map_tile,
    output logic [3:0] player_x,
    output logic [3:0] player_y,
    output logic [1:0] facing,
    output logic       moved,
    output logic       bomb_req,
    output logic [3:0] bomb_x,
    output logic [3:0] bomb_y
);

    localparam int CW = $clog2(MOVE_TICKS + 1);

    // Direction codes share the encoding of the facing output.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EVAL = 2'd2,
        S_COOL = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cool;
    logic [3:0]    r_player_x;
    logic [3:0]    r_player_y;
    logic [1:0]    r_facing;
    logic          r_map_rd_en;
    logic [3:0]    r_map_x;
    logic [3:0]    r_map_y;
    logic          r_moved;
    logic          r_bomb_req;
    logic [3:0]    r_bomb_x;
    logic [3:0]    r_bomb_y;
    logic          r_mid_q;

    logic          w_any_dir;
    logic [1:0]    w_dir;
    logic [4:0]    w_tx;
    logic [4:0]    w_ty;
    logic          w_off;
    logic          w_go;
    logic          w_launch;
    logic          w_commit;
    logic          w_cool_load;
    logic          w_cool_dec;
    logic          w_mid_rise;
    logic          w_bomb;

    // Pick the highest-priority pressed direction: Up > Down > Left > Right.
    always_comb begin
        w_any_dir = up_dpb | down_dpb | left_dpb | right_dpb;
        if (up_dpb) begin
            w_dir = DIR_UP;
        end else if (down_dpb) begin
            w_dir = DIR_DOWN;
        end else if (left_dpb) begin
            w_dir = DIR_LEFT;
        end else begin
            w_dir = DIR_RIGHT;
        end
    end

    // Target tile in 5 bits: stepping below 0 wraps to 31, which the
    // upper-bound compare rejects together with stepping past the far edge.
    always_comb begin
        w_tx = {1'b0, r_player_x};
        w_ty = {1'b0, r_player_y};
        case (w_dir)
            DIR_UP:    w_ty = {1'b0, r_player_y} - 5'd1;
            DIR_DOWN:  w_ty = {1'b0, r_player_y} + 5'd1;
            DIR_LEFT:  w_tx = {1'b0, r_player_x} - 5'd1;
            DIR_RIGHT: w_tx = {1'b0, r_player_x} + 5'd1;
            default: begin
                w_tx = {1'b0, r_player_x};
                w_ty = {1'b0, r_player_y};
            end
        endcase
        w_off = (w_tx > 5'(GRID_W - 1)) | (w_ty > 5'(GRID_H - 1));
    end

    // State register; respawn acts like a synchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else if (respawn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a dead player is always pulled back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = w_off ? S_COOL : S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ:  w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = S_COOL;
            S_COOL: begin
                if (r_cool == CW'(0)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_COOL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!alive) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // FSM decode: per-cycle actions applied by the datapath registers.
    always_comb begin
        w_go        = (r_state == S_IDLE) & alive & w_any_dir;
        w_launch    = w_go & ~w_off;
        // EVAL is the cycle in which the tile answer for map_x/y is valid.
        w_commit    = (r_state == S_EVAL) & alive & (map_tile == 2'd0);
        w_cool_load = alive & ((r_state == S_EVAL) | (w_go & w_off));
        w_cool_dec  = alive & (r_state == S_COOL) & (r_cool != CW'(0));
        w_mid_rise  = mid_dpb & ~r_mid_q;
        w_bomb      = w_mid_rise & alive & ~bomb_busy;
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_player_x  <= 4'(START_X);
            r_player_y  <= 4'(START_Y);
            r_facing    <= DIR_DOWN;
            r_cool      <= CW'(0);
            r_map_rd_en <= 1'b0;
            r_map_x     <= 4'd0;
            r_map_y     <= 4'd0;
            r_moved     <= 1'b0;
            r_bomb_req  <= 1'b0;
            r_bomb_x    <= 4'd0;
            r_bomb_y    <= 4'd0;
            r_mid_q     <= 1'b0;
        end else if (respawn) begin
            r_player_x  <= 4'(START_X);
            r_player_y  <= 4'(START_Y);
            r_facing    <= DIR_DOWN;
            r_cool      <= CW'(0);
            r_map_rd_en <= 1'b0;
            r_map_x     <= 4'd0;
            r_map_y     <= 4'd0;
            r_moved     <= 1'b0;
            r_bomb_req  <= 1'b0;
            r_bomb_x    <= 4'd0;
            r_bomb_y    <= 4'd0;
            r_mid_q     <= 1'b0;
        end else begin
            r_mid_q     <= mid_dpb;
            r_map_rd_en <= w_launch;
            r_moved     <= w_commit;
            r_bomb_req  <= w_bomb;
            if (w_go) begin
                r_facing <= w_dir;
            end
            if (w_launch) begin
                r_map_x <= w_tx[3:0];
                r_map_y <= w_ty[3:0];
            end
            // map_x/y still hold the target while EVAL samples the tile.
            if (w_commit) begin
                r_player_x <= r_map_x;
                r_player_y <= r_map_y;
            end
            // Bomb uses the position before any commit on this same edge.
            if (w_bomb) begin
                r_bomb_x <= r_player_x;
                r_bomb_y <= r_player_y;
            end
            if (!alive) begin
                r_cool <= CW'(0);
            end else if (w_cool_load) begin
                r_cool <= CW'(MOVE_TICKS - 1);
            end else if (w_cool_dec) begin
                r_cool <= r_cool - CW'(1);
            end
        end
    end

    assign map_rd_en = r_map_rd_en;
    assign map_x     = r_map_x;
    assign map_y     = r_map_y;
    assign player_x  = r_player_x;
    assign player_y  = r_player_y;
    assign facing    = r_facing;
    assign moved     = r_moved;
    assign bomb_req  = r_bomb_req;
    assign bomb_x    = r_bomb_x;
    assign bomb_y    = r_bomb_y;

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

    localparam int MT = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       up_dpb, down_dpb, left_dpb, right_dpb, mid_dpb;
    logic       alive, respawn, bomb_busy;
    logic       map_rd_en;
    logic [3:0] map_x, map_y;
    logic [1:0] map_tile = 2'd3;
    logic [3:0] player_x, player_y;
    logic [1:0] facing;
    logic       moved, bomb_req;
    logic [3:0] bomb_x, bomb_y;

    player_move_ctrl #(
        .GRID_W(15), .GRID_H(13), .START_X(1), .START_Y(1), .MOVE_TICKS(MT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .up_dpb(up_dpb), .down_dpb(down_dpb), .left_dpb(left_dpb),
        .right_dpb(right_dpb), .mid_dpb(mid_dpb),
        .alive(alive), .respawn(respawn), .bomb_busy(bomb_busy),
        .map_rd_en(map_rd_en), .map_x(map_x), .map_y(map_y),
        .map_tile(map_tile),
        .player_x(player_x), .player_y(player_y), .facing(facing),
        .moved(moved), .bomb_req(bomb_req), .bomb_x(bomb_x), .bomb_y(bomb_y)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Map model: answer one cycle after the strobe; any other cycle returns
    // a bomb code so a mistimed sample never looks like an empty tile.
    logic [3:0] blk_x = 4'd15, blk_y = 4'd15;
    logic [1:0] blk_code = 2'd0, def_code = 2'd0;

    function automatic logic [1:0] tile_at(input logic [3:0] x, input logic [3:0] y);
        if (x == blk_x && y == blk_y) return blk_code;
        else return def_code;
    endfunction

    always @(posedge CLK) map_tile <= map_rd_en ? tile_at(map_x, map_y) : 2'd3;

    // Scoreboard of expected output events.
    localparam logic [1:0] EV_RD = 2'd0, EV_MV = 2'd1, EV_BOMB = 2'd2;
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] x;
        logic [3:0] y;
    } ev_t;
    ev_t sbq[$];
    int  mv_cyc[$];
    int  rd_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [3:0] x, input logic [3:0] y);
        ev_t e;
        e.kind = k; e.x = x; e.y = y;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] k, input logic [3:0] x, input logic [3:0] y);
        ev_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            $display("FAIL sb_event: got kind %0d at (%0d,%0d) expected no event", k, x, y);
        end else begin
            e = sbq.pop_front();
            if (e.kind == k && e.x == x && e.y == y) n_pass++;
            else $display("FAIL sb_event: got kind %0d at (%0d,%0d) expected kind %0d at (%0d,%0d)",
                          k, x, y, e.kind, e.x, e.y);
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (map_rd_en) begin
                rd_cyc.push_back(cyc);
                sb_check(EV_RD, map_x, map_y);
            end
            if (moved) begin
                mv_cyc.push_back(cyc);
                sb_check(EV_MV, player_x, player_y);
            end
            if (bomb_req) sb_check(EV_BOMB, bomb_x, bomb_y);
        end
    end

    task automatic set_btn(input logic [3:0] b);
        {up_dpb, down_dpb, left_dpb, right_dpb} = b;
    endtask

    task automatic do_respawn();
        respawn = 1'b1;
        @(negedge CLK);
        respawn = 1'b0;
        @(negedge CLK);
    endtask

    // One press spanning a single active edge, then wait out the cooldown.
    task automatic step(input logic [3:0] b, input logic rd, input logic [3:0] tx,
                        input logic [3:0] ty, input logic mv);
        if (rd) push_ev(EV_RD, tx, ty);
        if (mv) push_ev(EV_MV, tx, ty);
        set_btn(b);
        @(negedge CLK);
        set_btn(4'b0000);
        repeat (9) @(negedge CLK);
    endtask

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        logic [1:0] tile;
        logic [3:0] tx, ty, ex, ey;
        logic [1:0] ef;
    } vec_t;
    vec_t vecs[10];

    int press_cyc;

    initial begin
        vecs[0] = '{4'b0001, 2'd0, 4'd2, 4'd1, 4'd2, 4'd1, 2'b11};
        vecs[1] = '{4'b0010, 2'd0, 4'd0, 4'd1, 4'd0, 4'd1, 2'b10};
        vecs[2] = '{4'b1000, 2'd0, 4'd1, 4'd0, 4'd1, 4'd0, 2'b00};
        vecs[3] = '{4'b0100, 2'd0, 4'd1, 4'd2, 4'd1, 4'd2, 2'b01};
        vecs[4] = '{4'b1001, 2'd0, 4'd1, 4'd0, 4'd1, 4'd0, 2'b00};
        vecs[5] = '{4'b0110, 2'd0, 4'd1, 4'd2, 4'd1, 4'd2, 2'b01};
        vecs[6] = '{4'b0011, 2'd0, 4'd0, 4'd1, 4'd0, 4'd1, 2'b10};
        vecs[7] = '{4'b0001, 2'd2, 4'd2, 4'd1, 4'd1, 4'd1, 2'b11};
        vecs[8] = '{4'b0100, 2'd3, 4'd1, 4'd2, 4'd1, 4'd1, 2'b01};
        vecs[9] = '{4'b1000, 2'd1, 4'd1, 4'd0, 4'd1, 4'd1, 2'b00};

        RESET = 1'b1;
        set_btn(4'b0000);
        mid_dpb = 1'b0; alive = 1'b1; respawn = 1'b0; bomb_busy = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Reset state
        chk("rst_x", player_x, 1);
        chk("rst_y", player_y, 1);
        chk("rst_facing", facing, 2'b01);
        chk("rst_rd_en", map_rd_en, 0);
        chk("rst_moved", moved, 0);
        chk("rst_bomb_req", bomb_req, 0);
        chk("rst_map_x", map_x, 0);

        // Single-step vectors from the start tile
        for (int i = 0; i < 10; i++) begin
            do_respawn();
            def_code = vecs[i].tile;
            step(vecs[i].btn, 1'b1, vecs[i].tx, vecs[i].ty, vecs[i].tile == 2'd0);
            chk($sformatf("vec%0d_x", i), player_x, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), player_y, vecs[i].ey);
            chk($sformatf("vec%0d_facing", i), facing, vecs[i].ef);
        end
        def_code = 2'd0;

        // Held Right: moves to x=2,3,4 every MT+3 cycles
        do_respawn();
        mv_cyc.delete();
        push_ev(EV_RD, 4'd2, 4'd1); push_ev(EV_MV, 4'd2, 4'd1);
        push_ev(EV_RD, 4'd3, 4'd1); push_ev(EV_MV, 4'd3, 4'd1);
        push_ev(EV_RD, 4'd4, 4'd1); push_ev(EV_MV, 4'd4, 4'd1);
        press_cyc = cyc;
        set_btn(4'b0001);
        repeat (17) @(negedge CLK);
        set_btn(4'b0000);
        repeat (10) @(negedge CLK);
        chk("hold_x", player_x, 4);
        chk("hold_nmoves", mv_cyc.size(), 3);
        if (mv_cyc.size() == 3) begin
            chk("hold_latency", mv_cyc[0] - press_cyc, 3);
            chk("hold_period1", mv_cyc[1] - mv_cyc[0], MT + 3);
            chk("hold_period2", mv_cyc[2] - mv_cyc[1], MT + 3);
        end

        // Hard wall above: read but no move, cooldown unchanged
        do_respawn();
        blk_x = 4'd1; blk_y = 4'd0; blk_code = 2'd1;
        rd_cyc.delete(); mv_cyc.delete();
        push_ev(EV_RD, 4'd1, 4'd0); push_ev(EV_RD, 4'd1, 4'd0);
        set_btn(4'b1000);
        repeat (10) @(negedge CLK);
        set_btn(4'b0000);
        repeat (10) @(negedge CLK);
        chk("wall_x", player_x, 1);
        chk("wall_y", player_y, 1);
        chk("wall_facing", facing, 2'b00);
        chk("wall_nmoves", mv_cyc.size(), 0);
        chk("wall_nreads", rd_cyc.size(), 2);
        if (rd_cyc.size() == 2) chk("wall_period", rd_cyc[1] - rd_cyc[0], MT + 3);
        blk_x = 4'd15; blk_y = 4'd15; blk_code = 2'd0;

        // Left edge at (0,5), then Up+Right together
        do_respawn();
        step(4'b0010, 1'b1, 4'd0, 4'd1, 1'b1);
        for (int k = 2; k <= 5; k++) step(4'b0100, 1'b1, 4'd0, 4'(k), 1'b1);
        chk("edge_pre_y", player_y, 5);
        step(4'b0010, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("edge_left_x", player_x, 0);
        chk("edge_left_facing", facing, 2'b10);
        step(4'b1001, 1'b1, 4'd0, 4'd4, 1'b1);
        chk("edge_prio_y", player_y, 4);
        chk("edge_prio_facing", facing, 2'b00);

        // Top edge
        do_respawn();
        step(4'b1000, 1'b1, 4'd1, 4'd0, 1'b1);
        step(4'b1000, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("top_y", player_y, 0);

        // Bomb: one request per rising edge, dropped while busy or dead
        do_respawn();
        step(4'b0001, 1'b1, 4'd2, 4'd1, 1'b1);
        step(4'b0001, 1'b1, 4'd3, 4'd1, 1'b1);
        push_ev(EV_BOMB, 4'd3, 4'd1);
        mid_dpb = 1'b1;
        repeat (6) @(negedge CLK);
        mid_dpb = 1'b0;
        repeat (2) @(negedge CLK);
        bomb_busy = 1'b1;
        mid_dpb = 1'b1;
        repeat (3) @(negedge CLK);
        mid_dpb = 1'b0; bomb_busy = 1'b0;
        repeat (2) @(negedge CLK);
        alive = 1'b0;
        mid_dpb = 1'b1;
        repeat (3) @(negedge CLK);
        mid_dpb = 1'b0; alive = 1'b1;
        repeat (2) @(negedge CLK);
        chk("bomb_sb_drained", sbq.size(), 0);

        // alive drops during EVAL: no commit
        do_respawn();
        push_ev(EV_RD, 4'd2, 4'd1);
        set_btn(4'b0001);
        @(negedge CLK);            // READ
        set_btn(4'b0000);
        @(negedge CLK);            // EVAL
        alive = 1'b0;
        @(negedge CLK);
        chk("dead_x", player_x, 1);
        chk("dead_moved", moved, 0);
        repeat (2) @(negedge CLK);
        alive = 1'b1;
        repeat (8) @(negedge CLK);
        chk("dead_x_after", player_x, 1);

        // Respawn in the middle of COOL returns straight to IDLE
        do_respawn();
        push_ev(EV_RD, 4'd2, 4'd1); push_ev(EV_MV, 4'd2, 4'd1);
        set_btn(4'b0001);
        @(negedge CLK);
        set_btn(4'b0000);
        repeat (3) @(negedge CLK);   // in COOL
        respawn = 1'b1;
        @(negedge CLK);
        respawn = 1'b0;
        chk("resp_x", player_x, 1);
        chk("resp_y", player_y, 1);
        chk("resp_facing", facing, 2'b01);
        push_ev(EV_RD, 4'd1, 4'd2); push_ev(EV_MV, 4'd1, 4'd2);
        set_btn(4'b0100);
        @(negedge CLK);
        set_btn(4'b0000);
        chk("resp_idle_rd", map_rd_en, 1);
        repeat (9) @(negedge CLK);
        chk("resp_down_y", player_y, 2);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
